layer_serializer: RTL and testbench
===================================

// Module: layer_serializer
// PURPOSE
//   Downstream stage of a fully-parallel neuron layer. Captures the layer's NUM_NEURON
//   parallel outputs as each neuron's valid bit arrives. Once every neuron has reported,
//   it streams the words out one per accepted handshake, in neuron order 0..NUM_NEURON-1.
//   The output feeds the single-word i_input/i_input_valid/o_input_ready port of the next layer.
// PARAMETERS
//   NUM_NEURON  10  number of neurons in the upstream layer (>=2)
//   DATA_WIDTH  16  width of one neuron output word
// PORTS
//   i_clk          in   1                      clock, rising edge
//   i_reset        in   1                      asynchronous, active-high reset
//   i_data         in   NUM_NEURON*DATA_WIDTH  upstream outputs; word k = i_data[k*DATA_WIDTH +: DATA_WIDTH]
//   i_data_valid   in   NUM_NEURON             per-neuron single-cycle valid pulses
//   o_data         out  DATA_WIDTH             serialized word
//   o_data_valid   out  1                      o_data holds a word to transfer
//   i_data_ready   in   1                      downstream accepts o_data this cycle
//   o_last         out  1                      high with o_data_valid on word NUM_NEURON-1
//   o_busy         out  1                      high in SEND state
//   o_overrun      out  1                      sticky error flag
// BEHAVIOUR
//   Reset (async, immediate): state=COLLECT, mask=0, idx=0, o_data_valid=0, o_last=0,
//     o_busy=0, o_overrun=0, o_data=0, all buffer words=0. This applies mid-transfer too;
//     any partial frame is discarded.
//   Storage: buffer of NUM_NEURON x DATA_WIDTH regs; mask[NUM_NEURON-1:0]; idx of $clog2(NUM_NEURON) bits.
//   COLLECT: for each k with i_data_valid[k]=1 at an edge:
//     - buf[k] <= word k; mask[k] <= 1.
//     - If mask[k] was already 1: overwrite buf[k] and set o_overrun.
//     - If (mask | i_data_valid) is all ones at that edge: go to SEND, idx <= 0, mask <= 0.
//     - Any subset of bits may arrive in one cycle, including all of them at once.
//   SEND: o_data = buf[idx]; o_data_valid=1; o_busy=1; o_last = (idx==NUM_NEURON-1).
//     - A transfer happens on an edge where o_data_valid && i_data_ready.
//     - On transfer: idx++. If idx was NUM_NEURON-1, go to COLLECT with idx <= 0.
//     - No transfer: o_data, idx and o_last hold stable. o_data_valid never drops before transfer.
//     - Any i_data_valid bit seen in SEND: data dropped, o_overrun set, mask unchanged.
//   Latency: the final missing valid at edge E -> o_data_valid high right after E.
//     With i_data_ready held high, word j transfers at edge E+1+j.
//     COLLECT is re-entered after edge E+NUM_NEURON.
//   Throughput: one word per cycle. Valid pulses arriving on the last-transfer edge still
//     count as SEND (dropped + overrun). The next frame is accepted from the following edge.
//   Widths: data passes through unmodified; no arithmetic on data.
//   o_overrun stays set until reset.
// TESTING
//   1. All 10 valid bits at edge E, ready=1, words 0x0100+k -> 0x0100..0x0109 transfer on
//      E+1..E+10; o_last only with 0x0109; o_busy falls after E+10.
//   2. Staggered valids (neuron 9 first, neuron 0 last, 3-cycle gaps) -> no o_data_valid
//      until neuron 0's edge; output order still 0..9.
//   3. ready toggled 1,0,0,1,... during SEND -> each word held stable while ready=0;
//      no word skipped or duplicated; 10 transfers total.
//   4. Valid pulse on bit 3 while in SEND -> o_overrun=1 and stays set; current frame
//      unaffected; next frame collected correctly.
//   5. Neuron 2 valid twice in COLLECT (0x1111 then 0x2222) -> word 2 sent as 0x2222;
//      o_overrun=1.
//   6. i_reset asserted after word 4 transfers -> outputs zero immediately; a new full
//      frame afterwards streams words 0..9 from idx 0.

Source files
------------

// File: rtl/layer_serializer.sv
// rtl/layer_serializer.sv - collects parallel neuron outputs and streams them one word per handshake
//
// Purpose:
//   Captures NUM_NEURON parallel words as each neuron's valid pulse arrives.
//   Once every neuron has reported, it streams the words out in neuron order.
//
// Ports:
//   i_clk, i_reset   clock (rising edge), asynchronous active-high reset
//   i_data           NUM_NEURON packed words, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_data_valid     per-neuron single-cycle valid pulses
//   o_data           serialized word (zero outside SEND)
//   o_data_valid     o_data holds a word to transfer
//   i_data_ready     downstream accepts o_data this cycle
//   o_last           high with o_data_valid on the final word of a frame
//   o_busy           high while streaming
//   o_overrun        sticky: a neuron reported twice in one frame, or reported while streaming
module layer_serializer #(
  parameter int NUM_NEURON = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic [NUM_NEURON*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_NEURON-1:0]            i_data_valid,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             o_data_valid,
  input  logic                             i_data_ready,
  output logic                             o_last,
  output logic                             o_busy,
  output logic                             o_overrun
);

  localparam int IDX_W = $clog2(NUM_NEURON);

  typedef enum logic {COLLECT, SEND} state_t;

  state_t                state, state_next;
  logic [NUM_NEURON-1:0] mask;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] word_buf [NUM_NEURON];
  logic                  overrun;
  logic                  frame_done;
  logic                  last_word;
  logic                  transfer;

  // The frame completes on the edge where the remaining neurons report,
  // so the incoming valids are merged with the mask before the test.
  assign frame_done = &(mask | i_data_valid);
  assign last_word  = (idx == IDX_W'(NUM_NEURON - 1));
  assign transfer   = o_data_valid && i_data_ready;
  assign o_overrun  = overrun;

  always_comb begin
    state_next   = state;
    o_data       = '0;
    o_data_valid = 1'b0;
    o_busy       = 1'b0;
    o_last       = 1'b0;
    case (state)
      COLLECT: begin
        if (frame_done) state_next = SEND;
      end
      SEND: begin
        o_data       = word_buf[idx];
        o_data_valid = 1'b1;
        o_busy       = 1'b1;
        o_last       = last_word;
        if (i_data_ready && last_word) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= COLLECT;
      mask    <= '0;
      idx     <= '0;
      overrun <= 1'b0;
      for (int k = 0; k < NUM_NEURON; k++) word_buf[k] <= '0;
    end else begin
      state <= state_next;
      case (state)
        COLLECT: begin
          for (int k = 0; k < NUM_NEURON; k++) begin
            if (i_data_valid[k]) begin
              word_buf[k] <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
              if (mask[k]) overrun <= 1'b1;
            end
          end
          if (frame_done) begin
            mask <= '0;
            idx  <= '0;
          end else begin
            mask <= mask | i_data_valid;
          end
        end
        SEND: begin
          // Words arriving mid-stream have nowhere to go; they are dropped.
          if (|i_data_valid) overrun <= 1'b1;
          if (transfer) idx <= last_word ? '0 : idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_serializer.sv
// tb/tb_layer_serializer.sv - randomized self-checking bench for layer_serializer
module tb_layer_serializer;

  localparam int N = 10;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] i_data;
  logic [N-1:0]   i_data_valid;
  logic [W-1:0]   o_data;
  logic           o_data_valid;
  logic           i_data_ready;
  logic           o_last;
  logic           o_busy;
  logic           o_overrun;

  layer_serializer #(.NUM_NEURON(N), .DATA_WIDTH(W)) dut (
    .i_clk(clk), .i_reset(rst), .i_data(i_data), .i_data_valid(i_data_valid),
    .o_data(o_data), .o_data_valid(o_data_valid), .i_data_ready(i_data_ready),
    .o_last(o_last), .o_busy(o_busy), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: latest word per neuron, which neurons have reported in the
  // current frame, and the expected sticky error state.
  logic [W-1:0] exp_words   [N];
  logic [W-1:0] frame_words [N];
  logic [N-1:0] seen;
  logic         exp_overrun;

  // Observed stream from the most recent capture.
  logic [W-1:0] got_w [$];
  logic         got_l [$];
  int           hold_bad;
  int           cycles;
  logic         timed_out;

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = W'($urandom);
    return r;
  endfunction

  // One cycle of valid pulses, issued while the DUT is collecting.
  task automatic pulse(input logic [N-1:0] v, input logic [N*W-1:0] d);
    i_data_valid = v;
    i_data       = d;
    for (int k = 0; k < N; k++) begin
      if (v[k]) begin
        if (seen[k]) exp_overrun = 1'b1;
        exp_words[k] = d[k*W +: W];
        seen[k]      = 1'b1;
      end
    end
    @(posedge clk); #1;
    i_data_valid = '0;
    if (&seen) begin
      frame_words = exp_words;
      seen        = '0;
    end
  endtask

  // Random subsets of the still-missing neurons with random idle gaps.
  task automatic fill_random(input int max_gap);
    logic [N-1:0] v;
    while (seen != '0 || 1'b1) begin
      v = N'($urandom_range(1, (1 << N) - 1)) & ~seen;
      if (v == '0) v = ~seen;
      pulse(v, rand_data());
      if (seen == '0) break;
      repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
    end
  endtask

  // Records every accepted word; mode 0 ready=1, 1 random, 2 pattern 1,0,0.
  task automatic capture(input int n, input int mode);
    int           cyc;
    logic         pend;
    logic [W-1:0] held;
    got_w.delete(); got_l.delete();
    hold_bad = 0; cyc = 0; pend = 1'b0; held = '0; timed_out = 1'b0;
    while (got_w.size() < n) begin
      if (cyc >= 300) begin timed_out = 1'b1; break; end
      case (mode)
        0:       i_data_ready = 1'b1;
        1:       i_data_ready = 1'($urandom_range(0, 1));
        default: i_data_ready = (cyc % 3 == 0);
      endcase
      @(negedge clk);
      if (pend && (!o_data_valid || o_data !== held)) hold_bad++;
      pend = 1'b0;
      if (o_data_valid && i_data_ready) begin
        got_w.push_back(o_data);
        got_l.push_back(o_last);
      end else if (o_data_valid) begin
        pend = 1'b1;
        held = o_data;
      end
      @(posedge clk); #1;
      cyc++;
    end
    i_data_ready = 1'b0;
    cycles = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_data = '0; i_data_valid = '0; i_data_ready = 1'b0;
    seen = '0; exp_overrun = 1'b0;
    repeat (2) @(posedge clk); #1;
    total++; if (o_data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b exp 0", o_data_valid); end
    total++; if (o_data !== '0)         begin bad++; $display("FAIL reset_data got %h exp 0", o_data); end
    total++; if ({o_last, o_busy, o_overrun} !== 3'b000) begin bad++; $display("FAIL reset_flags got %b exp 000", {o_last, o_busy, o_overrun}); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_all_at_once();
    logic [N*W-1:0] d;
    for (int k = 0; k < N; k++) d[k*W +: W] = W'(16'h0100 + k);
    pulse('1, d);
    total++; if (o_data_valid !== 1'b1) begin bad++; $display("FAIL all_latency got %b exp 1", o_data_valid); end
    capture(N, 0);
    total++; if (timed_out !== 1'b0 || cycles != N) begin bad++; $display("FAIL all_cycles got %0d exp %0d", cycles, N); end
    for (int j = 0; j < got_w.size(); j++) begin
      total++; if (got_w[j] !== W'(16'h0100 + j)) begin bad++; $display("FAIL all_word%0d got %h exp %h", j, got_w[j], W'(16'h0100 + j)); end
      total++; if (got_l[j] !== (j == N - 1))     begin bad++; $display("FAIL all_last%0d got %b exp %b", j, got_l[j], (j == N - 1)); end
    end
    total++; if (o_busy !== 1'b0 || o_data_valid !== 1'b0) begin bad++; $display("FAIL all_idle got busy=%b valid=%b exp 0 0", o_busy, o_data_valid); end
  endtask

  task automatic test_staggered();
    for (int n = N - 1; n >= 0; n--) begin
      pulse(N'(1) << n, rand_data());
      total++;
      if (o_data_valid !== (n == 0)) begin bad++; $display("FAIL stagger_valid n=%0d got %b exp %b", n, o_data_valid, (n == 0)); end
      if (n != 0) repeat (3) begin @(posedge clk); #1; end
    end
    capture(N, 1);
    total++; if (timed_out !== 1'b0 || got_w.size() != N) begin bad++; $display("FAIL stagger_count got %0d exp %0d", got_w.size(), N); end
    for (int j = 0; j < got_w.size(); j++) begin
      total++; if (got_w[j] !== frame_words[j]) begin bad++; $display("FAIL stagger_word%0d got %h exp %h", j, got_w[j], frame_words[j]); end
    end
  endtask

  task automatic test_ready_toggle();
    fill_random(2);
    capture(N, 2);
    total++; if (timed_out !== 1'b0 || got_w.size() != N) begin bad++; $display("FAIL toggle_count got %0d exp %0d", got_w.size(), N); end
    total++; if (hold_bad != 0) begin bad++; $display("FAIL toggle_hold got %0d exp 0", hold_bad); end
    for (int j = 0; j < got_w.size(); j++) begin
      total++; if (got_w[j] !== frame_words[j]) begin bad++; $display("FAIL toggle_word%0d got %h exp %h", j, got_w[j], frame_words[j]); end
      total++; if (got_l[j] !== (j == N - 1))   begin bad++; $display("FAIL toggle_last%0d got %b exp %b", j, got_l[j], (j == N - 1)); end
    end
    total++; if (o_overrun !== exp_overrun) begin bad++; $display("FAIL toggle_overrun got %b exp %b", o_overrun, exp_overrun); end
  endtask

  task automatic test_duplicate();
    logic [N*W-1:0] d;
    total++; if (o_overrun !== 1'b0) begin bad++; $display("FAIL dup_pre_overrun got %b exp 0", o_overrun); end
    d = rand_data(); d[2*W +: W] = 16'h1111;
    pulse(N'(1) << 2, d);
    d = rand_data(); d[2*W +: W] = 16'h2222;
    pulse(N'(1) << 2, d);
    fill_random(1);
    total++; if (o_overrun !== exp_overrun || exp_overrun !== 1'b1) begin bad++; $display("FAIL dup_overrun got %b exp 1", o_overrun); end
    capture(N, 1);
    total++; if (timed_out !== 1'b0 || got_w.size() != N) begin bad++; $display("FAIL dup_count got %0d exp %0d", got_w.size(), N); end
    for (int j = 0; j < got_w.size(); j++) begin
      total++; if (got_w[j] !== frame_words[j]) begin bad++; $display("FAIL dup_word%0d got %h exp %h", j, got_w[j], frame_words[j]); end
    end
    if (got_w.size() > 2) begin
      total++; if (got_w[2] !== 16'h2222) begin bad++; $display("FAIL dup_word2_value got %h exp 2222", got_w[2]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    fill_random(1);
    capture(5, 0);
    rst = 1'b1; #1;
    total++; if (o_data_valid !== 1'b0 || o_data !== '0) begin bad++; $display("FAIL midrst_out got valid=%b data=%h exp 0 0", o_data_valid, o_data); end
    total++; if ({o_last, o_busy, o_overrun} !== 3'b000) begin bad++; $display("FAIL midrst_flags got %b exp 000", {o_last, o_busy, o_overrun}); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    seen = '0; exp_overrun = 1'b0;
    fill_random(2);
    capture(N, 1);
    total++; if (timed_out !== 1'b0 || got_w.size() != N) begin bad++; $display("FAIL midrst_count got %0d exp %0d", got_w.size(), N); end
    for (int j = 0; j < got_w.size(); j++) begin
      total++; if (got_w[j] !== frame_words[j]) begin bad++; $display("FAIL midrst_word%0d got %h exp %h", j, got_w[j], frame_words[j]); end
    end
  endtask

  task automatic test_overrun_in_send();
    fill_random(1);
    i_data_valid = N'(1) << 3; i_data = rand_data(); i_data_ready = 1'b0;
    @(posedge clk); #1;
    i_data_valid = '0;
    exp_overrun = 1'b1;
    total++; if (o_overrun !== 1'b1) begin bad++; $display("FAIL send_overrun got %b exp 1", o_overrun); end
    total++; if (o_data_valid !== 1'b1 || o_data !== frame_words[0]) begin bad++; $display("FAIL send_hold got %h exp %h", o_data, frame_words[0]); end
    capture(N, 1);
    for (int j = 0; j < got_w.size(); j++) begin
      total++; if (got_w[j] !== frame_words[j]) begin bad++; $display("FAIL send_word%0d got %h exp %h", j, got_w[j], frame_words[j]); end
    end
    fill_random(3);
    capture(N, 0);
    total++; if (timed_out !== 1'b0 || got_w.size() != N) begin bad++; $display("FAIL send_next_count got %0d exp %0d", got_w.size(), N); end
    for (int j = 0; j < got_w.size(); j++) begin
      total++; if (got_w[j] !== frame_words[j]) begin bad++; $display("FAIL send_next_word%0d got %h exp %h", j, got_w[j], frame_words[j]); end
    end
    total++; if (o_overrun !== 1'b1) begin bad++; $display("FAIL send_sticky got %b exp 1", o_overrun); end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      pulse('1, rand_data());
      total++; if (o_data_valid !== 1'b1) begin bad++; $display("FAIL b2b_latency%0d got %b exp 1", f, o_data_valid); end
      capture(N, 0);
      total++; if (timed_out !== 1'b0 || cycles != N) begin bad++; $display("FAIL b2b_cycles%0d got %0d exp %0d", f, cycles, N); end
      for (int j = 0; j < got_w.size(); j++) begin
        total++; if (got_w[j] !== frame_words[j]) begin bad++; $display("FAIL b2b_word%0d_%0d got %h exp %h", f, j, got_w[j], frame_words[j]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_at_once();
    test_staggered();
    test_ready_toggle();
    test_duplicate();
    test_reset_mid_frame();
    test_overrun_in_send();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
